multiply_divide_unit: RTL and testbench

MULTIPLY_DIVIDE_UNIT -- requirements
Module: multiply_divide_unit

---
 rtl/multiply_divide_unit.sv | 111 +++++++++++
 tb/tb_multiply_divide_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multiply_divide_unit.sv
// HI/LO multiply/divide unit: fixed-latency mult (5 cycles) and div (10 cycles)
// with move-to writes; results land in HI/LO only at the final busy edge.
module multiply_divide_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  ctrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        stall_request
);

   typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

   state_t      state, next_state;
   logic [3:0]  count, next_count;
   logic [31:0] op_a, op_b, next_op_a, next_op_b;
   logic        op_unsigned, next_op_unsigned;
   logic [31:0] next_hi, next_lo;

   logic [63:0] ext_a, ext_b, product;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quotient, remainder;

   assign busy          = (state != IDLE);
   assign stall_request = busy | ctrl[4];

   // Divide on magnitudes and fix signs afterwards, so 0x80000000 / -1 simply
   // wraps back to 0x80000000 instead of hitting a signed-overflow corner.
   always_comb begin
      ext_a     = op_unsigned ? {32'd0, op_a} : {{32{op_a[31]}}, op_a};
      ext_b     = op_unsigned ? {32'd0, op_b} : {{32{op_b[31]}}, op_b};
      product   = ext_a * ext_b;
      a_neg     = !op_unsigned && op_a[31];
      b_neg     = !op_unsigned && op_b[31];
      a_mag     = a_neg ? (~op_a + 32'd1) : op_a;
      b_mag     = b_neg ? (~op_b + 32'd1) : op_b;
      divisor   = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag     = a_mag / divisor;
      r_mag     = a_mag % divisor;
      quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      remainder = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

   always_comb begin
      next_state       = state;
      next_count       = count;
      next_op_a        = op_a;
      next_op_b        = op_b;
      next_op_unsigned = op_unsigned;
      next_hi          = HI;
      next_lo          = LO;
      case (state)
         IDLE: begin
            if (ctrl[4]) begin
               next_state       = ctrl[3] ? DIV : MULT;
               next_count       = ctrl[3] ? 4'd10 : 4'd5;
               next_op_a        = A;
               next_op_b        = B;
               next_op_unsigned = ctrl[2];
            end else if (ctrl[1]) begin
               if (ctrl[0]) next_lo = A;
               else         next_hi = A;
            end
         end
         MULT: begin
            next_count = count - 4'd1;
            if (count == 4'd1) begin
               next_state = IDLE;
               next_hi    = product[63:32];
               next_lo    = product[31:0];
            end
         end
         DIV: begin
            next_count = count - 4'd1;
            // A zero divisor still burns the full latency but leaves HI/LO alone.
            if (count == 4'd1) begin
               next_state = IDLE;
               if (op_b != 32'd0) begin
                  next_hi = remainder;
                  next_lo = quotient;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= 4'd0;
         op_a        <= 32'd0;
         op_b        <= 32'd0;
         op_unsigned <= 1'b0;
         HI          <= 32'd0;
         LO          <= 32'd0;
      end else begin
         state       <= next_state;
         count       <= next_count;
         op_a        <= next_op_a;
         op_b        <= next_op_b;
         op_unsigned <= next_op_unsigned;
         HI          <= next_hi;
         LO          <= next_lo;
      end
   end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed bench for multiply_divide_unit: latencies, results, move-to,
// divide corner cases, reset abort and robustness against illegal issue.
module tb_multiply_divide_unit;

   logic        clk;
   logic        reset_n;
   logic [4:0]  ctrl;
   logic [31:0] A, B;
   logic [31:0] HI, LO;
   logic        busy, stall_request;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] C_MULT  = 5'b10000;
   localparam logic [4:0] C_MULTU = 5'b10100;
   localparam logic [4:0] C_DIV   = 5'b11000;
   localparam logic [4:0] C_DIVU  = 5'b11100;
   localparam logic [4:0] C_MTHI  = 5'b00010;
   localparam logic [4:0] C_MTLO  = 5'b00011;
   localparam logic [4:0] C_MFLO  = 5'b01001;

   multiply_divide_unit dut (
      .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .A(A), .B(B),
      .HI(HI), .LO(LO), .busy(busy), .stall_request(stall_request)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one operation, scrambles operands while it runs and counts busy cycles.
   task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit stable);
      logic [31:0] h0, l0;
      @(negedge clk);
      h0 = HI; l0 = LO;
      ctrl = c; A = a; B = b;
      @(negedge clk);
      ctrl = 5'b0; A = $urandom; B = $urandom;
      cycles = 0; stable = 1'b1;
      while (busy && cycles < 30) begin
         cycles++;
         if (HI !== h0 || LO !== l0) stable = 1'b0;
         @(negedge clk);
         A = $urandom; B = $urandom;
      end
   endtask

   task automatic move_to(input logic [4:0] c, input logic [31:0] a);
      @(negedge clk);
      ctrl = c; A = a;
      @(negedge clk);
      ctrl = 5'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ctrl = 5'b0; A = 32'd0; B = 32'd0;
      repeat (3) @(negedge clk);
      checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got %h want 0", LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (stall_request !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall_request); end
      reset_n = 1'b1;
   endtask

   task automatic test_stall_request();
      @(negedge clk);
      ctrl = C_MFLO; #1;
      checks++; if (stall_request !== 1'b0) begin errors++; $display("[TB] FAIL stall_mflo got %b want 0", stall_request); end
      ctrl = C_MULT; A = 32'd1; B = 32'd1; #1;
      checks++; if (stall_request !== 1'b1) begin errors++; $display("[TB] FAIL stall_launch got %b want 1", stall_request); end
      @(negedge clk);
      ctrl = 5'b0;
      checks++; if (stall_request !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy got %b want 1", stall_request); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_mult();
      int cyc; bit st;
      run_op(C_MULT, 32'hFFFFFFFE, 32'd3, cyc, st);
      checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL mult_busy got %0d want 5", cyc); end
      checks++; if (!st) begin errors++; $display("[TB] FAIL mult_stable got 0 want 1"); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo got %h want fffffffa", LO); end
      run_op(C_MULTU, 32'hFFFFFFFE, 32'd3, cyc, st);
      checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL multu_busy got %0d want 5", cyc); end
      checks++; if (HI !== 32'h00000002) begin errors++; $display("[TB] FAIL multu_hi got %h want 00000002", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL multu_lo got %h want fffffffa", LO); end
   endtask

   task automatic test_div();
      int cyc; bit st;
      run_op(C_DIV, 32'hFFFFFFF9, 32'd2, cyc, st);
      checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL div_busy got %0d want 10", cyc); end
      checks++; if (!st) begin errors++; $display("[TB] FAIL div_stable got 0 want 1"); end
      checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo got %h want fffffffd", LO); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi got %h want ffffffff", HI); end
      run_op(C_DIVU, 32'd7, 32'd2, cyc, st);
      checks++; if (LO !== 32'd3) begin errors++; $display("[TB] FAIL divu_lo got %h want 3", LO); end
      checks++; if (HI !== 32'd1) begin errors++; $display("[TB] FAIL divu_hi got %h want 1", HI); end
      run_op(C_DIV, 32'd7, 32'hFFFFFFFE, cyc, st);
      checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_negb_lo got %h want fffffffd", LO); end
      checks++; if (HI !== 32'd1) begin errors++; $display("[TB] FAIL div_negb_hi got %h want 1", HI); end
      run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, st);
      checks++; if (LO !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", LO); end
      checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL div_ovf_hi got %h want 0", HI); end
   endtask

   task automatic test_div_zero();
      int cyc; bit st;
      move_to(C_MTHI, 32'h11);
      move_to(C_MTLO, 32'h22);
      run_op(C_DIV, 32'd5, 32'd0, cyc, st);
      checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL divz_busy got %0d want 10", cyc); end
      checks++; if (HI !== 32'h11) begin errors++; $display("[TB] FAIL divz_hi got %h want 11", HI); end
      checks++; if (LO !== 32'h22) begin errors++; $display("[TB] FAIL divz_lo got %h want 22", LO); end
   endtask

   task automatic test_move_to();
      @(negedge clk);
      ctrl = C_MTHI; A = 32'h1234;
      @(negedge clk);
      ctrl = C_MTLO; A = 32'h5678;
      checks++; if (HI !== 32'h1234) begin errors++; $display("[TB] FAIL mthi_next got %h want 1234", HI); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy got %b want 0", busy); end
      @(negedge clk);
      ctrl = C_MFLO; A = 32'hDEAD;
      checks++; if (LO !== 32'h5678) begin errors++; $display("[TB] FAIL mtlo_lo got %h want 5678", LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy got %b want 0", busy); end
      @(negedge clk);
      ctrl = 5'b0;
      checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin errors++; $display("[TB] FAIL mflo_nochange got %h/%h want 1234/5678", HI, LO); end
   endtask

   task automatic test_reset_mid_op();
      int cyc; bit st;
      @(negedge clk);
      ctrl = C_MULT; A = 32'd9; B = 32'd9;
      @(negedge clk);
      ctrl = 5'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0; ctrl = C_MULT; A = 32'd2; B = 32'd2; #1;
      checks++; if (stall_request !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall got %b want 1", stall_request); end
      @(negedge clk);
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("[TB] FAIL rst_abort got %h/%h want 0/0", HI, LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      reset_n = 1'b1; ctrl = 5'b0;
      run_op(C_MULT, 32'd3, 32'd4, cyc, st);
      checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL rst_relaunch_busy got %0d want 5", cyc); end
      checks++; if (HI !== 32'd0 || LO !== 32'd12) begin errors++; $display("[TB] FAIL rst_relaunch got %h/%h want 0/c", HI, LO); end
   endtask

   task automatic test_ignore_while_busy();
      int cyc;
      @(negedge clk);
      ctrl = C_MULT; A = 32'd2; B = 32'd3;
      @(negedge clk);
      cyc = busy ? 1 : 0;
      ctrl = C_DIV; A = 32'd5; B = 32'd1;
      @(negedge clk);
      if (busy) cyc++;
      ctrl = C_MTLO; A = 32'hFF;
      @(negedge clk);
      ctrl = 5'b0;
      while (busy && cyc < 30) begin
         cyc++;
         @(negedge clk);
      end
      checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL ignore_busy got %0d want 5", cyc); end
      checks++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("[TB] FAIL ignore_result got %h/%h want 0/6", HI, LO); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || LO !== 32'd6) begin errors++; $display("[TB] FAIL ignore_after got busy %b lo %h want 0/6", busy, LO); end
   endtask

   initial begin
      test_reset();
      test_stall_request();
      test_mult();
      test_div();
      test_div_zero();
      test_move_to();
      test_reset_mid_op();
      test_ignore_while_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
